// File: rtl/frame_history_if.sv
// rtl/frame_history_if.sv - sensor, pair, writeback and status signals around the frame history store
interface frame_history_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_pix;
  logic                  pair_valid;
  logic [DATA_WIDTH-1:0] pair_new;
  logic [DATA_WIDTH-1:0] pair_old;
  logic                  wb_valid;
  logic [DATA_WIDTH-1:0] wb_pix;
  logic                  hist_ready;
  logic                  frame_err;

  // Sensor plus filter side: drives pixels and corrected writebacks
  modport master (
    output in_valid, in_sof, in_pix, wb_valid, wb_pix,
    input  pair_valid, pair_new, pair_old, hist_ready, frame_err
  );

  // History store side
  modport slave (
    input  in_valid, in_sof, in_pix, wb_valid, wb_pix,
    output pair_valid, pair_new, pair_old, hist_ready, frame_err
  );
endinterface

// File: rtl/frame_history.sv
// rtl/frame_history.sv - previous-frame store pairing each sensor pixel with its filtered history
module frame_history #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 48,
  parameter int ADDR_WIDTH = 12
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  frame_history_if.slave bus_io
);
  localparam int NPIX = FRAME_W * FRAME_H;
  localparam int CW   = $clog2(NPIX + 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [CW-1:0]         FULL_CNT  = CW'(NPIX);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {EMPTY, FILL, VALID} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read side
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, rd_addr;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  seen_q, seen_d;        // an sof has been seen since reset
  logic                  track_q, track_d;      // current frame started at an sof with no error since
  logic                  use_hist_q, use_hist_d; // RAM holds a complete previous frame for this one
  logic                  rd_sof, err_short, err_long, err_now;

  // Pair registers
  logic                  pair_valid_q, pair_sof_q, bypass_q;
  logic [DATA_WIDTH-1:0] pair_new_q;

  // Write side
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, wr_addr;
  logic                  sof_pend_q, sof_pend_d;
  logic                  wr_active_q, wr_active_d;
  logic                  clean_q, clean_d;      // write side filling from an sof with no frame error
  logic                  wr_en, wr_first, wr_last;

  logic                  hist_ready_q, frame_err_q;

  assign rd_sof    = bus_io.in_valid & bus_io.in_sof;
  assign rd_addr   = rd_sof ? '0 : rd_ptr_q;
  assign err_short = rd_sof & seen_q & (cnt_q != FULL_CNT);
  assign err_long  = bus_io.in_valid & ~bus_io.in_sof & seen_q & (cnt_q == FULL_CNT);
  assign err_now   = err_short | err_long;

  assign wr_first = bus_io.wb_valid & sof_pend_q;
  assign wr_en    = bus_io.wb_valid & (wr_active_q | sof_pend_q);
  assign wr_addr  = sof_pend_q ? '0 : wr_ptr_q;
  assign wr_last  = wr_en & (wr_addr == LAST_ADDR);

  // Read pointer, frame pixel counter and per-frame history qualification
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    track_d    = track_q;
    use_hist_d = use_hist_q;
    if (bus_io.in_valid) begin
      rd_ptr_d = (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_ONE;
      if (bus_io.in_sof) begin
        cnt_d      = CNT_ONE;
        seen_d     = 1'b1;
        use_hist_d = track_q & ~err_short;
        track_d    = 1'b1;
      end else if (err_long) begin
        // Pointers have wrapped, so this pixel counts as the first of the next pass
        cnt_d      = CNT_ONE;
        use_hist_d = 1'b0;
        track_d    = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Write pointer restarts at 0 on the first writeback after a delayed sof
  always_comb begin
    sof_pend_d  = (pair_valid_q & pair_sof_q) | (sof_pend_q & ~bus_io.wb_valid);
    wr_active_d = wr_active_q | wr_first;
    wr_ptr_d    = wr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_ONE;
    end
    clean_d = clean_q;
    if (err_now) begin
      clean_d = 1'b0;
    end else if (wr_first) begin
      clean_d = 1'b1;
    end
  end

  // History state: frame errors take priority over completing a fill
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (rd_sof) state_d = FILL;
      FILL:    if (!err_now && wr_last && clean_q) state_d = VALID;
      VALID:   if (err_now) state_d = FILL;
      default: state_d = EMPTY;
    endcase
  end

  // Frame RAM: read-first, contents survive reset
  always_ff @(posedge clk_i) begin
    if (bus_io.in_valid) rd_data_q <= mem[rd_addr];
    if (wr_en)           mem[wr_addr] <= bus_io.wb_pix;
  end

  // Control and output registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= EMPTY;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      seen_q       <= 1'b0;
      track_q      <= 1'b0;
      use_hist_q   <= 1'b0;
      pair_valid_q <= 1'b0;
      pair_sof_q   <= 1'b0;
      bypass_q     <= 1'b1;
      pair_new_q   <= '0;
      wr_ptr_q     <= '0;
      sof_pend_q   <= 1'b0;
      wr_active_q  <= 1'b0;
      clean_q      <= 1'b0;
      hist_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      track_q      <= track_d;
      use_hist_q   <= use_hist_d;
      pair_valid_q <= bus_io.in_valid;
      if (bus_io.in_valid) begin
        pair_new_q <= bus_io.in_pix;
        pair_sof_q <= bus_io.in_sof;
        bypass_q   <= ~use_hist_d;
      end
      wr_ptr_q     <= wr_ptr_d;
      sof_pend_q   <= sof_pend_d;
      wr_active_q  <= wr_active_d;
      clean_q      <= clean_d;
      hist_ready_q <= (state_d == VALID);
      frame_err_q  <= err_now;
    end
  end

  assign bus_io.pair_valid = pair_valid_q;
  assign bus_io.pair_new   = pair_new_q;
  assign bus_io.pair_old   = bypass_q ? pair_new_q : rd_data_q;
  assign bus_io.hist_ready = hist_ready_q;
  assign bus_io.frame_err  = frame_err_q;
endmodule
